dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the shared RAM port of the data memory arbiter.
// No storage. All signals are plain wires.
// master = requesters plus the RAM model; slave = the arbiter.
interface dmem_arbiter_if;
  logic        m0_req_in;
  logic        m0_lock_in;
  logic [31:0] m0_addr_in;
  logic [31:0] m0_data_in;
  logic [3:0]  m0_we_in;
  logic        m0_gnt_out;
  logic        m0_rvalid_out;
  logic [31:0] m0_data_out;

  logic        m1_req_in;
  logic        m1_lock_in;
  logic [31:0] m1_addr_in;
  logic [31:0] m1_data_in;
  logic [3:0]  m1_we_in;
  logic        m1_gnt_out;
  logic        m1_rvalid_out;
  logic [31:0] m1_data_out;

  logic [31:0] ram_addr_out;
  logic [31:0] ram_data_out;
  logic [3:0]  ram_write_enable_out;
  logic [31:0] ram_data_in;

  modport master (
    output m0_req_in, m0_lock_in, m0_addr_in, m0_data_in, m0_we_in,
    input  m0_gnt_out, m0_rvalid_out, m0_data_out,
    output m1_req_in, m1_lock_in, m1_addr_in, m1_data_in, m1_we_in,
    input  m1_gnt_out, m1_rvalid_out, m1_data_out,
    input  ram_addr_out, ram_data_out, ram_write_enable_out,
    output ram_data_in
  );

  modport slave (
    input  m0_req_in, m0_lock_in, m0_addr_in, m0_data_in, m0_we_in,
    output m0_gnt_out, m0_rvalid_out, m0_data_out,
    input  m1_req_in, m1_lock_in, m1_addr_in, m1_data_in, m1_we_in,
    output m1_gnt_out, m1_rvalid_out, m1_data_out,
    output ram_addr_out, ram_data_out, ram_write_enable_out,
    input  ram_data_in
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data memory arbiter: round-robin with bounded lock ownership, read-return routing.
// Grant and RAM address are combinational (zero added latency); read data returns RAM_LATENCY cycles later.
// A requester holds req and payload until granted; the lock is broken after MAX_LOCK contested grants.
module dmem_arbiter #(
  parameter int RAM_LATENCY = 2,
  parameter int MAX_LOCK    = 16
) (
  input logic           clk_in,
  input logic           rst_in,
  dmem_arbiter_if.slave bus
);

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} own_e;

  own_e       state_q, state_d;
  logic [7:0] lock_cnt, cnt_d;
  logic       rr_last;
  logic [1:0] req, lock, gnt;
  logic       brk, owner_m1, rd_acc;
  logic [3:0] we_g;

  logic [RAM_LATENCY-1:0] tag_vld, tag_id;
  logic [31:0]            data0_q, data1_q;
  logic                   rv0, rv1;

  assign req      = {bus.m1_req_in,  bus.m0_req_in};
  assign lock     = {bus.m1_lock_in, bus.m0_lock_in};
  assign owner_m1 = (state_q == OWN_M1);
  // A lock that has collected MAX_LOCK contested grants is ignored from this cycle on.
  assign brk      = (state_q != OWN_NONE) && (lock_cnt >= MAX_LOCK_C);

  // Ownership / lock counter / round-robin registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= OWN_NONE;
      lock_cnt <= 8'd0;
      rr_last  <= 1'b1;
    end else begin
      state_q  <= state_d;
      lock_cnt <= cnt_d;
      if (|gnt) rr_last <= gnt[1];
    end
  end

  // Grant selection and next ownership; a broken lock falls back to round-robin.
  always_comb begin
    gnt     = 2'b00;
    state_d = state_q;
    cnt_d   = lock_cnt;
    if (!rst_in) begin
      gnt = 2'b00;
    end else if (state_q != OWN_NONE && !brk) begin
      gnt = owner_m1 ? {req[1], 1'b0} : {1'b0, req[0]};
    end else if (&req) begin
      gnt = rr_last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end

    if (|gnt) begin
      if (gnt[1] ? lock[1] : lock[0]) begin
        state_d = gnt[1] ? OWN_M1 : OWN_M0;
        // Only grants made while the other side is waiting count toward the limit.
        if (state_q == state_d && !brk)
          cnt_d = lock_cnt + {7'd0, (gnt[1] ? req[0] : req[1])};
        else
          cnt_d = {7'd0, (gnt[1] ? req[0] : req[1])};
      end else begin
        state_d = OWN_NONE;
        cnt_d   = 8'd0;
      end
    end else if (state_q != OWN_NONE &&
                 (brk || (!req[owner_m1] && !lock[owner_m1]))) begin
      state_d = OWN_NONE;
      cnt_d   = 8'd0;
    end
  end

  assign bus.m0_gnt_out = gnt[0];
  assign bus.m1_gnt_out = gnt[1];

  assign bus.ram_addr_out = gnt[0] ? bus.m0_addr_in :
                            gnt[1] ? bus.m1_addr_in : 32'd0;
  assign bus.ram_data_out = gnt[0] ? bus.m0_data_in :
                            gnt[1] ? bus.m1_data_in : 32'd0;
  assign we_g             = gnt[0] ? bus.m0_we_in :
                            gnt[1] ? bus.m1_we_in : 4'd0;
  assign bus.ram_write_enable_out = we_g;
  assign rd_acc = (|gnt) && (we_g == 4'd0);

  // Read tag pipeline: one stage per cycle of RAM latency; reset drops in-flight reads.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= rd_acc;
      tag_id[0]  <= gnt[1];
      for (int i = 1; i < RAM_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign rv0 = tag_vld[RAM_LATENCY-1] && !tag_id[RAM_LATENCY-1];
  assign rv1 = tag_vld[RAM_LATENCY-1] &&  tag_id[RAM_LATENCY-1];

  // Last returned read data per requester, held between returns.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data0_q <= 32'd0;
      data1_q <= 32'd0;
    end else begin
      if (rv0) data0_q <= bus.ram_data_in;
      if (rv1) data1_q <= bus.ram_data_in;
    end
  end

  assign bus.m0_rvalid_out = rv0;
  assign bus.m1_rvalid_out = rv1;
  assign bus.m0_data_out   = rv0 ? bus.ram_data_in : data0_q;
  assign bus.m1_data_out   = rv1 ? bus.ram_data_in : data1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: scripted requester stimulus, a RAM model with fixed latency,
// and a read-return scoreboard filled when a read is expected to be accepted.
module tb_dmem_arbiter;
  localparam int LAT = 2;
  localparam int ML  = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  dmem_arbiter_if bus();

  dmem_arbiter #(.RAM_LATENCY(LAT), .MAX_LOCK(ML)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic        exp_last  = 1'b1;
  logic [31:0] last0     = 32'd0;
  logic [31:0] last1     = 32'd0;

  function automatic logic [31:0] ram_f(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  // RAM model: read data for the address presented LAT cycles ago.
  logic [31:0] ram_pipe [LAT];
  always @(posedge clk_in) begin
    ram_pipe[0] <= bus.ram_addr_out;
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bus.ram_data_in = ram_f(ram_pipe[LAT-1]);

  // Scoreboard: every read return must match the oldest expected read.
  always @(negedge clk_in) begin
    exp_t        e;
    logic        rid;
    logic [31:0] rd;
    if (rst_in && (bus.m0_rvalid_out === 1'b1 || bus.m1_rvalid_out === 1'b1)) begin
      total_cnt++;
      rid = bus.m1_rvalid_out;
      rd  = rid ? bus.m1_data_out : bus.m0_data_out;
      if (bus.m0_rvalid_out === 1'b1 && bus.m1_rvalid_out === 1'b1) begin
        $display("FAIL rvalid_both: got both rvalid high, expected at most one");
      end else if (sb.size() == 0) begin
        $display("FAIL unexpected_rvalid: got rvalid on m%0d data %h, expected none", rid, rd);
      end else begin
        e = sb.pop_front();
        if (e.id !== rid || e.data !== rd)
          $display("FAIL read_return: got m%0d data %h, expected m%0d data %h", rid, rd, e.id, e.data);
        else
          pass_cnt++;
      end
    end
  end

  task automatic drive(input int m, input logic r, input logic l,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    if (m == 0) begin
      bus.m0_req_in = r; bus.m0_lock_in = l; bus.m0_addr_in = a;
      bus.m0_data_in = d; bus.m0_we_in = w;
    end else begin
      bus.m1_req_in = r; bus.m1_lock_in = l; bus.m1_addr_in = a;
      bus.m1_data_in = d; bus.m1_we_in = w;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_read(input logic id, input logic [31:0] a);
    exp_t e;
    e.id   = id;
    e.data = ram_f(a);
    sb.push_back(e);
    if (id) last1 = e.data; else last0 = e.data;
  endtask

  task automatic apply_reset();
    rst_in = 1'b0;
    idle_all();
    tick(); tick();
    rst_in   = 1'b1;
    exp_last = 1'b1;
    last0    = 32'd0;
    last1    = 32'd0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h123, 32'h1, 4'd0);
    drive(1, 1'b1, 1'b1, 32'h456, 32'h2, 4'hF);
    @(negedge clk_in);
    total_cnt++;
    if ({bus.m0_gnt_out, bus.m1_gnt_out} !== 2'b00)
      $display("FAIL reset_gnt: got %b, expected 00", {bus.m0_gnt_out, bus.m1_gnt_out});
    else pass_cnt++;
    total_cnt++;
    if ({bus.m0_rvalid_out, bus.m1_rvalid_out} !== 2'b00)
      $display("FAIL reset_rvalid: got %b, expected 00", {bus.m0_rvalid_out, bus.m1_rvalid_out});
    else pass_cnt++;
    total_cnt++;
    if (bus.m0_data_out !== 32'd0 || bus.m1_data_out !== 32'd0)
      $display("FAIL reset_data: got %h/%h, expected 0/0", bus.m0_data_out, bus.m1_data_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.ram_write_enable_out !== 4'd0 || bus.ram_addr_out !== 32'd0)
      $display("FAIL reset_ram: got we %h addr %h, expected 0 0",
               bus.ram_write_enable_out, bus.ram_addr_out);
    else pass_cnt++;
    apply_reset();
  endtask

  task automatic test_single_read();
    drive(0, 1'b1, 1'b0, 32'h100, 32'd0, 4'd0);
    @(negedge clk_in);
    total_cnt++;
    if ({bus.m1_gnt_out, bus.m0_gnt_out} !== 2'b01 || bus.ram_addr_out !== 32'h100 ||
        bus.ram_write_enable_out !== 4'd0)
      $display("FAIL single_grant: got gnt %b addr %h we %h, expected 01 100 0",
               {bus.m1_gnt_out, bus.m0_gnt_out}, bus.ram_addr_out, bus.ram_write_enable_out);
    else pass_cnt++;
    push_read(1'b0, 32'h100);
    exp_last = 1'b0;
    tick();
    idle_all();
    @(negedge clk_in);
    total_cnt++;
    if (bus.m0_rvalid_out !== 1'b0)
      $display("FAIL single_early: got rvalid %b at cycle 1, expected 0", bus.m0_rvalid_out);
    else pass_cnt++;
    tick();
    @(negedge clk_in);
    total_cnt++;
    if (bus.m0_rvalid_out !== 1'b1 || bus.m0_data_out !== ram_f(32'h100))
      $display("FAIL single_return: got rvalid %b data %h, expected 1 %h",
               bus.m0_rvalid_out, bus.m0_data_out, ram_f(32'h100));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_write();
    drive(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 4'b0011);
    @(negedge clk_in);
    total_cnt++;
    if (bus.m0_gnt_out !== 1'b1 || bus.ram_write_enable_out !== 4'b0011 ||
        bus.ram_addr_out !== 32'h40 || bus.ram_data_out !== 32'hDEADBEEF)
      $display("FAIL write_bus: got gnt %b we %b addr %h data %h, expected 1 0011 40 deadbeef",
               bus.m0_gnt_out, bus.ram_write_enable_out, bus.ram_addr_out, bus.ram_data_out);
    else pass_cnt++;
    exp_last = 1'b0;
    tick();
    idle_all();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      total_cnt++;
      if (bus.m0_rvalid_out !== 1'b0)
        $display("FAIL write_no_rvalid: got rvalid %b cycle %0d, expected 0", bus.m0_rvalid_out, c);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_round_robin();
    int          i0, i1;
    logic        g;
    logic [31:0] a0, a1;
    apply_reset();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 6; c++) begin
      a0 = 32'h200 + 32'(4 * i0);
      a1 = 32'h300 + 32'(4 * i1);
      drive(0, 1'b1, 1'b0, a0, 32'd0, 4'd0);
      drive(1, 1'b1, 1'b0, a1, 32'd0, 4'd0);
      @(negedge clk_in);
      g = ~exp_last;
      total_cnt++;
      if ({bus.m1_gnt_out, bus.m0_gnt_out} !== (g ? 2'b10 : 2'b01))
        $display("FAIL rr_grant: cycle %0d got %b, expected %b", c,
                 {bus.m1_gnt_out, bus.m0_gnt_out}, (g ? 2'b10 : 2'b01));
      else pass_cnt++;
      if (g) begin push_read(1'b1, a1); i1++; end
      else   begin push_read(1'b0, a0); i0++; end
      exp_last = g;
      tick();
    end
    idle_all();
    repeat (LAT + 1) tick();
  endtask

  task automatic test_lock_break();
    logic g;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    @(negedge clk_in);
    total_cnt++;
    if (bus.m0_gnt_out !== 1'b1)
      $display("FAIL lock_pre: got m0 gnt %b, expected 1", bus.m0_gnt_out);
    else pass_cnt++;
    exp_last = 1'b0;
    tick();
    for (int k = 0; k <= ML; k++) begin
      drive(1, 1'b1, 1'b1, 32'h600 + 32'(k), 32'(k), 4'hF);
      drive(0, 1'b1, 1'b0, 32'h500, 32'd0, 4'd0);
      @(negedge clk_in);
      g = (k < ML);
      total_cnt++;
      if ({bus.m1_gnt_out, bus.m0_gnt_out} !== (g ? 2'b10 : 2'b01))
        $display("FAIL lock_grant: step %0d got %b, expected %b", k,
                 {bus.m1_gnt_out, bus.m0_gnt_out}, (g ? 2'b10 : 2'b01));
      else pass_cnt++;
      if (!g) begin
        total_cnt++;
        if (bus.ram_write_enable_out !== 4'd0 || bus.ram_addr_out !== 32'h500)
          $display("FAIL lock_break_bus: got we %h addr %h, expected 0 500",
                   bus.ram_write_enable_out, bus.ram_addr_out);
        else pass_cnt++;
        push_read(1'b0, 32'h500);
      end
      exp_last = g;
      tick();
    end
    idle_all();
    repeat (LAT + 1) tick();
  endtask

  task automatic test_lock_release();
    drive(0, 1'b1, 1'b1, 32'h20, 32'h5, 4'hF);
    @(negedge clk_in);
    total_cnt++;
    if (bus.m0_gnt_out !== 1'b1)
      $display("FAIL rel_take: got m0 gnt %b, expected 1", bus.m0_gnt_out);
    else pass_cnt++;
    exp_last = 1'b0;
    tick();
    drive(0, 1'b0, 1'b1, 32'h0, 32'h0, 4'd0);
    drive(1, 1'b1, 1'b0, 32'h800, 32'h0, 4'd0);
    @(negedge clk_in);
    total_cnt++;
    if ({bus.m1_gnt_out, bus.m0_gnt_out} !== 2'b00)
      $display("FAIL rel_hold_idle: got %b, expected 00", {bus.m1_gnt_out, bus.m0_gnt_out});
    else pass_cnt++;
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk_in);
    total_cnt++;
    if (bus.m1_gnt_out !== 1'b0)
      $display("FAIL rel_drop_cycle: got m1 gnt %b, expected 0", bus.m1_gnt_out);
    else pass_cnt++;
    tick();
    @(negedge clk_in);
    total_cnt++;
    if (bus.m1_gnt_out !== 1'b1)
      $display("FAIL rel_next: got m1 gnt %b, expected 1", bus.m1_gnt_out);
    else pass_cnt++;
    push_read(1'b1, 32'h800);
    exp_last = 1'b1;
    tick();
    idle_all();
    repeat (LAT + 1) tick();
  endtask

  task automatic test_hold_data();
    @(negedge clk_in);
    total_cnt++;
    if (bus.m0_rvalid_out !== 1'b0 || bus.m0_data_out !== last0)
      $display("FAIL hold_m0: got rvalid %b data %h, expected 0 %h",
               bus.m0_rvalid_out, bus.m0_data_out, last0);
    else pass_cnt++;
    total_cnt++;
    if (bus.m1_rvalid_out !== 1'b0 || bus.m1_data_out !== last1)
      $display("FAIL hold_m1: got rvalid %b data %h, expected 0 %h",
               bus.m1_rvalid_out, bus.m1_data_out, last1);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 1'b1, 1'b0, 32'h700, 32'd0, 4'd0);
    @(negedge clk_in);
    total_cnt++;
    if (bus.m1_gnt_out !== 1'b1)
      $display("FAIL mid_grant: got m1 gnt %b, expected 1", bus.m1_gnt_out);
    else pass_cnt++;
    tick();
    rst_in = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h900, 32'h0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk_in);
    total_cnt++;
    if ({bus.m0_gnt_out, bus.m1_gnt_out, bus.m0_rvalid_out, bus.m1_rvalid_out} !== 4'd0 ||
        bus.m0_data_out !== 32'd0 || bus.m1_data_out !== 32'd0 ||
        bus.ram_write_enable_out !== 4'd0 || bus.ram_addr_out !== 32'd0 ||
        bus.ram_data_out !== 32'd0)
      $display("FAIL mid_reset_outputs: got gnt %b%b rv %b%b data %h/%h ram %h/%h/%h, expected all 0",
               bus.m0_gnt_out, bus.m1_gnt_out, bus.m0_rvalid_out, bus.m1_rvalid_out,
               bus.m0_data_out, bus.m1_data_out, bus.ram_write_enable_out,
               bus.ram_addr_out, bus.ram_data_out);
    else pass_cnt++;
    tick();
    idle_all();
    rst_in   = 1'b1;
    exp_last = 1'b1;
    last0    = 32'd0;
    last1    = 32'd0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk_in);
      total_cnt++;
      if (bus.m1_rvalid_out !== 1'b0 || bus.m0_rvalid_out !== 1'b0)
        $display("FAIL mid_no_rvalid: cycle %0d got %b%b, expected 00", c,
                 bus.m0_rvalid_out, bus.m1_rvalid_out);
      else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_lock_break();
    test_lock_release();
    test_hold_data();
    test_reset_mid();
    total_cnt++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
